// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: sequences PC and IF/ID updates,
// inserts bubbles for load-use, branch redirects, fetch misses and multi-cycle mul/div.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             ImemReady,
    input  logic             PerfClr,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             FlushD,
    output logic             FlushE,
    output logic             StallE,
    output logic             MdDoneE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]    state;
    logic [0:0]    next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          load_use;
    logic          flush_evt;

    assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        StallE      = 1'b0;
        MdDoneE     = 1'b0;
        flush_evt   = 1'b0;
        next_state  = state;
        next_cnt    = cnt;
        if (!rst) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            next_state  = RUN;
            next_cnt    = '0;
        end else if (state == MD_BUSY) begin
            // The mul/div op sits in Execute until release, so its inputs are ignored here.
            if (cnt != '0) begin
                StallE      = 1'b1;
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                next_cnt    = cnt - 1'b1;
            end else begin
                MdDoneE    = 1'b1;
                next_state = RUN;
            end
        end else if (PCSrcE) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            flush_evt = 1'b1;
        end else if (MdStartE) begin
            StallE      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            next_cnt    = CW'(MD_LATENCY - 2);
            next_state  = MD_BUSY;
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            FlushE      = 1'b1;
        end else if (!ImemReady) begin
            PCWrite = 1'b0;
            FlushD  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Clear takes precedence over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (PerfClr) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && (StallCount != '1))
                StallCount <= StallCount + CNT_W'(1);
            if (flush_evt && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a cycle model of the stall/flush rules checked
// every cycle against two instances (MD_LATENCY=4/CNT_W=32 and MD_LATENCY=2/CNT_W=4).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       MemReadE, PCSrcE, MdStartE, ImemReady, PerfClr;

    logic        a_pcw, a_ifw, a_fd, a_fe, a_se, a_done;
    logic [31:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_fd, b_fe, b_se, b_done;
    logic [3:0]  b_stall, b_flush;

    int checks = 0;
    int passes = 0;

    int     lat[2]   = '{4, 2};
    int     cw[2]    = '{32, 4};
    bit     md_on[2] = '{0, 0};
    int     md_age[2] = '{0, 0};
    longint m_stall[2] = '{0, 0};
    longint m_flush[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .ImemReady(ImemReady), .PerfClr(PerfClr),
        .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .FlushD(a_fd), .FlushE(a_fe),
        .StallE(a_se), .MdDoneE(a_done), .StallCount(a_stall), .FlushCount(a_flush)
    );

    hazard_stall_ctrl #(.MD_LATENCY(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .ImemReady(ImemReady), .PerfClr(PerfClr),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .FlushD(b_fd), .FlushE(b_fe),
        .StallE(b_se), .MdDoneE(b_done), .StallCount(b_stall), .FlushCount(b_flush)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected {PCWrite, IF_ID_Write, FlushD, FlushE, StallE, MdDoneE} for model i.
    function automatic logic [5:0] model_outs(input int i);
        logic hazard;
        hazard = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst !== 1'b1)           return 6'b001100;
        if (md_on[i])               return (md_age[i] < lat[i] - 1) ? 6'b000010 : 6'b110001;
        if (PCSrcE)                 return 6'b111100;
        if (MdStartE)               return 6'b000010;
        if (hazard)                 return 6'b000100;
        if (!ImemReady)             return 6'b011000;
        return 6'b110000;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst !== 1'b1) begin
                md_on[i] = 0; md_age[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                logic [5:0] o;
                longint     cmax;
                o    = model_outs(i);
                cmax = (longint'(1) << cw[i]) - 1;
                if (PerfClr) begin
                    m_stall[i] = 0; m_flush[i] = 0;
                end else begin
                    if (!o[5] && m_stall[i] < cmax) m_stall[i]++;
                    if (!md_on[i] && PCSrcE && m_flush[i] < cmax) m_flush[i]++;
                end
                if (md_on[i]) begin
                    if (md_age[i] == lat[i] - 1) md_on[i] = 0;
                    else md_age[i]++;
                end else if (!PCSrcE && MdStartE) begin
                    md_on[i] = 1; md_age[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("outs_a",  {a_pcw, a_ifw, a_fd, a_fe, a_se, a_done}, model_outs(0));
        check("outs_b",  {b_pcw, b_ifw, b_fd, b_fe, b_se, b_done}, model_outs(1));
        check("stall_a", a_stall, m_stall[0]);
        check("flush_a", a_flush, m_flush[0]);
        check("stall_b", b_stall, m_stall[1]);
        check("flush_b", b_flush, m_flush[1]);
    end

    task automatic idle();
        MemReadE = 0; PCSrcE = 0; MdStartE = 0; PerfClr = 0; ImemReady = 1;
        RdE = 0; Rs1D = 0; Rs2D = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_pcw", a_pcw, 1'b0);
        check("rst_fd",  {a_fd, a_fe, a_se}, 3'b110);
        cyc(); rst = 1'b1;
        @(negedge clk);
        check("idle_pcw", a_pcw, 1'b1);
        check("idle_stall", a_stall, 32'd0);

        // Load-use, then same registers with RdE=0
        cyc(); MemReadE = 1; RdE = 5; Rs1D = 5;
        @(negedge clk);
        check("lu_pcw_ifw_fe", {a_pcw, a_ifw, a_fe}, 3'b001);
        cyc(); RdE = 0;
        @(negedge clk);
        check("lu_x0_pcw_fe", {a_pcw, a_fe}, 2'b10);
        check("lu_stall1", a_stall, 32'd1);

        // Redirect beats a simultaneous load-use
        cyc(); RdE = 5; PCSrcE = 1;
        @(negedge clk);
        check("br_pcw_fd_fe", {a_pcw, a_fd, a_fe}, 3'b111);
        cyc(); idle();
        @(negedge clk);
        check("br_flush1", a_flush, 32'd1);
        check("br_stall1", a_stall, 32'd1);

        // Mul/div held for four cycles
        cyc(); PerfClr = 1;
        cyc(); PerfClr = 0; MdStartE = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (k < 3) check("md_stall", {a_se, a_pcw, a_done}, 3'b100);
            else       check("md_done",  {a_se, a_pcw, a_done}, 3'b011);
            if (k == 1) check("md2_done", b_done, 1'b1);
        end
        cyc(); idle();
        @(negedge clk);
        check("md_stall3", a_stall, 32'd3);

        // Fetch misses
        cyc(); ImemReady = 0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            check("imem_bubble", {a_pcw, a_ifw, a_fd}, 3'b011);
        end
        cyc(); ImemReady = 1;
        @(negedge clk);
        check("imem_restore", {a_pcw, a_ifw, a_fd}, 3'b110);

        // Reset in the middle of a mul/div
        cyc(); MdStartE = 1;
        cyc(); MdStartE = 0;
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("md_rst_outs", {a_pcw, a_fd, a_fe, a_se}, 4'b0110);
        cyc(); rst = 1'b1;
        @(negedge clk);
        check("md_rst_run", {a_pcw, a_se}, 2'b10);
        check("md_rst_cnt", {a_stall, a_flush}, 64'd0);

        // Saturation on the 4-bit instance, then clear winning over increment
        cyc(); MemReadE = 1; RdE = 7; Rs2D = 7;
        for (int k = 1; k < 20; k++) cyc();
        cyc(); idle();
        @(negedge clk);
        check("sat_b", b_stall, 4'd15);
        check("sat_a", a_stall, 32'd20);
        cyc(); PerfClr = 1; MemReadE = 1; RdE = 7; Rs2D = 7;
        cyc(); idle();
        @(negedge clk);
        check("clr_b", b_stall, 4'd0);
        check("clr_a", a_stall, 32'd0);

        cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
